hss_envelope_peak: RTL and testbench
====================================

# hss_envelope_peak

Downstream stage of `db_wavelet`: consumes the absolute-value wavelet samples qualified by its `write_enable`, forms a moving-average envelope over a power-of-two window, and detects envelope peaks (candidate S1/S2 heart sounds) with a refractory hold-off. Output peaks (value and sample index) feed the segmentation logic and the RISC-V readout registers.

## Interface
- `WIN_LOG2`, 3: log2 of moving-average window length (window = 2^WIN_LOG2 samples, 1..10).
- `REFRACT`, 16: number of envelope samples suppressed after a reported peak (≥1).
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset, asynchronous, active-high.
- `in_data`  in  32  unsigned abs sample from `db_wavelet.output_abs_data`.
- `in_valid`  in  1  sample strobe, wired to `db_wavelet.write_enable`; one sample per high cycle.
- `threshold`  in  32  unsigned envelope threshold; quasi-static (software register).
- `env_data`  out  32  current envelope value.
- `env_valid`  out  1  one-cycle strobe, `env_data` updated.
- `peak_valid`  out  1  one-cycle strobe, peak reported.
- `peak_value`  out  32  envelope maximum of the reported peak.
- `peak_index`  out  32  input sample index at which that maximum occurred.

## Operation
- Sample counter `idx` (32 bit) increments per accepted `in_valid`; first sample after reset has index 0; wraps modulo 2^32.
- Window: circular buffer of 2^WIN_LOG2 × 32 bit, write pointer wraps modulo window length. Buffer is not cleared on reset; a fill counter marks slots unwritten since reset, and the subtracted old value is forced to 0 for those.
- Running sum, width 32+WIN_LOG2, unsigned, never overflows: `sum ← sum + in_data − old`. `env_data = sum >> WIN_LOG2` (truncating). Envelope of max input 0xFFFFFFFF stays 0xFFFFFFFF.
- Peak FSM, advances only on `env_valid`:
  - IDLE: if `env_data > threshold` → TRACK, load max = env_data, max_idx = index of producing sample.
  - TRACK: if `env_data > threshold`: replace max/max_idx only when strictly greater (ties keep first). If `env_data ≤ threshold`: pulse `peak_valid` with max/max_idx, load refractory counter = REFRACT, → REFRACT.
  - REFRACT: decrement per env sample, threshold ignored; on reaching 0 → IDLE (the sample on which the count expires is not evaluated).
- `threshold` is compared as sampled in the cycle of the envelope evaluation; changes mid-peak take effect on the next env sample.
- Reset mid-operation: all state, pointers, fill counter, sum, idx cleared; any in-progress peak is discarded, not reported.

## Timing
- Reset values: `env_data`=0, `env_valid`=0, `peak_valid`=0, `peak_value`=0, `peak_index`=0; FSM in IDLE.
- `in_valid` at cycle t → `env_valid`/`env_data` at t+1.
- Falling-edge env sample at t+1 → `peak_valid` at t+2; `peak_value`/`peak_index` hold until the next peak.
- Back-to-back `in_valid` every cycle sustained, no stall, no backpressure; gaps of any length allowed, no state change while `in_valid`=0.
- Outputs all registered.

## Structure
- Shared package/header `hss_pkg`: FSM state encodings (IDLE, TRACK, REFRACT), sample/index width constant (32).
- Sub-module `env_window_buf`: circular buffer with write pointer, fill counter and read-old-value port (1-cycle read-before-write); top holds sum, idx, FSM.

## Test plan
WIN_LOG2=2, REFRACT=3, unless noted.
- Reset: RST high, random `in_valid` → all outputs 0; release → first env after one sample of 0x10000000 is 0x04000000.
- Fill/steady: 0x10000000 every cycle → env 0x04000000, 0x08000000, 0x0C000000, 0x10000000, then constant 0x10000000; no peak with threshold 0xFFFFFFFF.
- Peak: threshold 0x08000000; inputs 0x10000000 ×4, then 0 ×4 → env …0x0C,0x10,0x0C,0x08 (×2^24); `peak_valid` one cycle after env 0x08000000, value 0x10000000, index 3.
- Refractory: second identical pulse starting immediately after zero run → env above threshold within 3 env samples after the peak ignored; pulse after ≥3 samples reported with correct index.
- Gapped input: scenario 3 with `in_valid` every third cycle → identical env/peak values and indices.
- Reset mid-peak and saturation: RST asserted in TRACK → no `peak_valid`; then 0xFFFFFFFF ×4 → env 0x3FFFFFFF, 0x7FFFFFFF, 0xBFFFFFFF, 0xFFFFFFFF, no wrap.

Source files
------------

// File: rtl/hss_pkg.sv
// Shared definitions for the heart-sound envelope/peak pipeline.
package hss_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_REFRACT
  } peak_state_e;

endpackage

// File: rtl/env_window_buf.sv
// Circular window buffer: presents the value about to be overwritten
// (zero for slots not yet written since reset) and writes the new one.
module env_window_buf
  import hss_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] old_data
);

  localparam int unsigned DEPTH = 1 << WIN_LOG2;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [WIN_LOG2-1:0] wr_ptr;
  logic [WIN_LOG2:0]   fill;
  logic                full;

  // Fill saturates at DEPTH, so its top bit alone flags a full window.
  assign full     = fill[WIN_LOG2];
  assign old_data = full ? mem[wr_ptr] : '0;

  // Write pointer and fill counter advance once per accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + WIN_LOG2'(1);
      if (!full) fill <= fill + (WIN_LOG2 + 1)'(1);
    end
  end

  // Sample storage; contents survive reset, the fill counter masks them.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hss_envelope_peak.sv
// Moving-average envelope of abs wavelet samples with thresholded peak
// detection and a refractory hold-off after each reported peak.
module hss_envelope_peak
  import hss_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 3,
  parameter int unsigned REFRACT  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] threshold,
  output logic [DATA_W-1:0] env_data,
  output logic              env_valid,
  output logic              peak_valid,
  output logic [DATA_W-1:0] peak_value,
  output logic [DATA_W-1:0] peak_index
);

  localparam int unsigned SUM_W = DATA_W + WIN_LOG2;

  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic [DATA_W-1:0] old_data;
  logic [DATA_W-1:0] idx;
  logic [DATA_W-1:0] env_idx;

  peak_state_e       state, state_next;
  logic [DATA_W-1:0] max_val, max_val_next;
  logic [DATA_W-1:0] max_idx, max_idx_next;
  logic [DATA_W-1:0] rcnt, rcnt_next;
  logic              fire;

  env_window_buf #(
    .WIN_LOG2(WIN_LOG2)
  ) u_win (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (in_valid),
    .wr_data (in_data),
    .old_data(old_data)
  );

  // Sum always covers exactly the buffered samples, so it cannot underflow.
  assign sum_next = sum + SUM_W'(in_data) - SUM_W'(old_data);

  // Running sum, sample index and registered envelope output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sum       <= '0;
      idx       <= '0;
      env_idx   <= '0;
      env_data  <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= in_valid;
      if (in_valid) begin
        sum      <= sum_next;
        env_data <= DATA_W'(sum_next >> WIN_LOG2);
        env_idx  <= idx;
        idx      <= idx + DATA_W'(1);
      end
    end
  end

  // Peak FSM state, tracked maximum and registered peak report.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= ST_IDLE;
      max_val    <= '0;
      max_idx    <= '0;
      rcnt       <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_index <= '0;
    end else begin
      state      <= state_next;
      max_val    <= max_val_next;
      max_idx    <= max_idx_next;
      rcnt       <= rcnt_next;
      peak_valid <= fire;
      if (fire) begin
        peak_value <= max_val;
        peak_index <= max_idx;
      end
    end
  end

  // Next-state logic; evaluated only when a fresh envelope sample is out.
  always_comb begin
    state_next   = state;
    max_val_next = max_val;
    max_idx_next = max_idx;
    rcnt_next    = rcnt;
    fire         = 1'b0;
    if (env_valid) begin
      case (state)
        ST_IDLE: begin
          if (env_data > threshold) begin
            state_next   = ST_TRACK;
            max_val_next = env_data;
            max_idx_next = env_idx;
          end
        end
        ST_TRACK: begin
          if (env_data > threshold) begin
            if (env_data > max_val) begin
              max_val_next = env_data;
              max_idx_next = env_idx;
            end
          end else begin
            fire       = 1'b1;
            rcnt_next  = DATA_W'(REFRACT);
            state_next = ST_REFRACT;
          end
        end
        ST_REFRACT: begin
          rcnt_next = rcnt - DATA_W'(1);
          if (rcnt == DATA_W'(1)) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hss_envelope_peak.sv
// Scoreboard bench for hss_envelope_peak: a sample-history reference model
// queues expected envelopes/peaks, a negedge monitor pops and compares.
module tb_hss_envelope_peak;

  localparam int unsigned WIN_LOG2 = 2;
  localparam int unsigned REFRACT  = 3;
  localparam int unsigned DEPTH    = 1 << WIN_LOG2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [31:0] threshold = 32'hFFFF_FFFF;
  logic [31:0] env_data;
  logic        env_valid;
  logic        peak_valid;
  logic [31:0] peak_value;
  logic [31:0] peak_index;

  hss_envelope_peak #(
    .WIN_LOG2(WIN_LOG2),
    .REFRACT (REFRACT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .threshold (threshold),
    .env_data  (env_data),
    .env_valid (env_valid),
    .peak_valid(peak_valid),
    .peak_value(peak_value),
    .peak_index(peak_index)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] envq[$];
  logic [63:0] pkq[$];

  // reference model state
  logic [31:0] hist[$];
  bit          m_tracking;
  int unsigned m_holdoff;
  logic [31:0] m_best;
  logic [31:0] m_best_idx;
  logic [31:0] m_idx;

  // monitor-observed peaks
  int          pk_count = 0;
  logic [31:0] last_pk_val = '0;
  logic [31:0] last_pk_idx = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    envq.delete();
    pkq.delete();
    m_tracking = 1'b0;
    m_holdoff  = 0;
    m_best     = '0;
    m_best_idx = '0;
    m_idx      = '0;
  endtask

  // Envelope = mean of the last DEPTH samples (missing ones count as 0).
  task automatic model_sample(input logic [31:0] d);
    longint unsigned s;
    logic [31:0] env;
    hist.push_back(d);
    if (hist.size() > DEPTH) void'(hist.pop_front());
    s = 0;
    foreach (hist[i]) s += longint'(hist[i]);
    env = 32'(s >> WIN_LOG2);
    envq.push_back(env);
    if (m_holdoff > 0) begin
      m_holdoff--;
    end else if (m_tracking) begin
      if (env > threshold) begin
        if (env > m_best) begin
          m_best     = env;
          m_best_idx = m_idx;
        end
      end else begin
        pkq.push_back({m_best, m_best_idx});
        m_tracking = 1'b0;
        m_holdoff  = REFRACT;
      end
    end else if (env > threshold) begin
      m_tracking = 1'b1;
      m_best     = env;
      m_best_idx = m_idx;
    end
    m_idx++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    model_sample(d);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      @(negedge CLK);
      check("rst_env_data", {32'h0, env_data}, 64'h0);
      check("rst_env_valid", {63'h0, env_valid}, 64'h0);
      check("rst_peak_valid", {63'h0, peak_valid}, 64'h0);
      check("rst_peak_value", {32'h0, peak_value}, 64'h0);
      check("rst_peak_index", {32'h0, peak_index}, 64'h0);
      @(posedge CLK);
      #1;
    end
    in_valid = 1'b0;
    RST = 1'b0;
    tick();
  endtask

  // monitor: every envelope/peak strobe must match the head of its queue
  always @(negedge CLK) begin
    if (!RST) begin
      if (env_valid) begin
        if (envq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL env_extra: got env_valid with env %h, required no strobe", env_data);
        end else begin
          check("env_data", {32'h0, env_data}, {32'h0, envq.pop_front()});
        end
      end
      if (peak_valid) begin
        pk_count++;
        last_pk_val = peak_value;
        last_pk_idx = peak_index;
        if (pkq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL peak_extra: got peak %h@%h, required no peak", peak_value, peak_index);
        end else begin
          check("peak", {peak_value, peak_index}, pkq.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int pk0;
    model_reset();

    // reset with random in_valid, then first sample and window fill
    threshold = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 8; i++) send(32'h1000_0000);
    gap(4);
    check("fill_no_peak", 64'(pk_count), 64'h0);

    // single pulse then zero run; peak at index 3
    threshold = 32'h0800_0000;
    do_reset();
    pk0 = pk_count;
    for (int i = 0; i < 4; i++) send(32'h1000_0000);
    for (int i = 0; i < 4; i++) send(32'h0);
    gap(2);
    check("pulse_peak_count", 64'(pk_count - pk0), 64'h1);
    check("pulse_peak_value", {32'h0, last_pk_val}, 64'h1000_0000);
    check("pulse_peak_index", {32'h0, last_pk_idx}, 64'h3);

    // second pulse during/after hold-off with a lower threshold
    threshold = 32'h0200_0000;
    pk0 = pk_count;
    for (int i = 0; i < 4; i++) send(32'h1000_0000);
    for (int i = 0; i < 4; i++) send(32'h0);
    gap(2);
    check("refract_peak_count", 64'(pk_count - pk0), 64'h1);
    check("refract_peak_index", {32'h0, last_pk_idx}, 64'd11);

    // same pulse with in_valid every third cycle
    threshold = 32'h0800_0000;
    do_reset();
    pk0 = pk_count;
    for (int i = 0; i < 8; i++) begin
      send(i < 4 ? 32'h1000_0000 : 32'h0);
      gap(2);
    end
    gap(2);
    check("gapped_peak_count", 64'(pk_count - pk0), 64'h1);
    check("gapped_peak_value", {32'h0, last_pk_val}, 64'h1000_0000);
    check("gapped_peak_index", {32'h0, last_pk_idx}, 64'h3);

    // reset while tracking discards the peak; then saturating input
    pk0 = pk_count;
    for (int i = 0; i < 4; i++) send(32'h1000_0000);
    gap(2);
    check("pending_env_before_reset", 64'(envq.size()), 64'h0);
    threshold = 32'hFFFF_FFFF;
    do_reset();
    for (int i = 0; i < 6; i++) send(32'hFFFF_FFFF);
    gap(4);
    check("midpeak_reset_no_peak", 64'(pk_count - pk0), 64'h0);

    // randomized samples, gaps and threshold
    threshold = 32'h3000_0000 + $urandom_range(0, 32'h2000_0000);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       send($urandom);
        1:       send(32'hC000_0000 + $urandom_range(0, 32'h3FFF_FFFF));
        default: send($urandom_range(0, 32'h0FFF_FFFF));
      endcase
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    gap(4);

    check("env_queue_drained", 64'(envq.size()), 64'h0);
    check("peak_queue_drained", 64'(pkq.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
